// File: rtl/z80_call_cond_seq.sv
// Execute-phase sequencer for CALL cc,nn (and CALL nn): reads the 16-bit target
// operand, evaluates the condition and, when taken, pushes the return address high byte first.
module z80_call_cond_seq #(
  parameter bit          ALLOW_UNCOND = 1'b1,
  parameter logic [15:0] RET_OFFSET   = 16'h0003
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  opcode,
  input  logic [7:0]  reg_f,
  input  logic [15:0] ip_in,
  input  logic [15:0] sp_in,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic [2:0]  mem_tcycles,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        taken,
  output logic [15:0] ip_out,
  output logic [15:0] sp_out,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_HI, WR_LO, FIN} state_t;

  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;

  state_t      state_reg;
  logic        met_reg;
  logic [15:0] ip_reg;
  logic [15:0] sp_reg;
  logic [7:0]  wlo_reg;
  logic [7:0]  whi_reg;

  logic        is_cc;
  logic        is_uncond;
  logic        opcode_ok;
  logic        flag;
  logic        cond_met;
  logic [15:0] ret_addr;

  // cond pairs share a flag; the low bit of cond selects the polarity tested
  always_comb begin
    is_cc     = (opcode & 8'hC7) == 8'hC4;
    is_uncond = ALLOW_UNCOND && (opcode == 8'hCD);
    opcode_ok = is_cc || is_uncond;
    case (opcode[5:4])
      2'd0:    flag = reg_f[6];
      2'd1:    flag = reg_f[0];
      2'd2:    flag = reg_f[2];
      default: flag = reg_f[7];
    endcase
    cond_met = is_uncond || (flag == opcode[3]);
  end

  assign ret_addr = ip_reg + RET_OFFSET;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      met_reg     <= 1'b0;
      ip_reg      <= 16'h0000;
      sp_reg      <= 16'h0000;
      wlo_reg     <= 8'h00;
      whi_reg     <= 8'h00;
      mem_req     <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= 16'h0000;
      mem_wdata   <= 8'h00;
      mem_tcycles <= 3'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      taken       <= 1'b0;
      ip_out      <= 16'h0000;
      sp_out      <= 16'h0000;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (opcode_ok) begin
              met_reg   <= cond_met;
              ip_reg    <= ip_in;
              sp_reg    <= sp_in;
              busy      <= 1'b1;
              state_reg <= RD_LO;
            end else begin
              err <= 1'b1;
            end
          end
        end

        // Each bus state spends its entry cycle with mem_req low, then holds
        // the request until the ack edge completes the transfer.
        RD_LO: begin
          if (!mem_req) begin
            mem_req     <= 1'b1;
            mem_wr      <= 1'b0;
            mem_addr    <= ip_reg + 16'd1;
            mem_tcycles <= T3;
          end else if (mem_ack) begin
            mem_req   <= 1'b0;
            wlo_reg   <= mem_rdata;
            state_reg <= RD_HI;
          end
        end

        RD_HI: begin
          if (!mem_req) begin
            mem_req     <= 1'b1;
            mem_wr      <= 1'b0;
            mem_addr    <= ip_reg + 16'd2;
            mem_tcycles <= met_reg ? T4 : T3;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            whi_reg <= mem_rdata;
            if (met_reg) begin
              state_reg <= WR_HI;
            end else begin
              taken     <= 1'b0;
              ip_out    <= ret_addr;
              sp_out    <= sp_reg;
              done      <= 1'b1;
              state_reg <= FIN;
            end
          end
        end

        WR_HI: begin
          if (!mem_req) begin
            mem_req     <= 1'b1;
            mem_wr      <= 1'b1;
            mem_addr    <= sp_reg - 16'd1;
            mem_wdata   <= ret_addr[15:8];
            mem_tcycles <= T3;
          end else if (mem_ack) begin
            mem_req   <= 1'b0;
            state_reg <= WR_LO;
          end
        end

        WR_LO: begin
          if (!mem_req) begin
            mem_req     <= 1'b1;
            mem_wr      <= 1'b1;
            mem_addr    <= sp_reg - 16'd2;
            mem_wdata   <= ret_addr[7:0];
            mem_tcycles <= T3;
          end else if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            taken     <= 1'b1;
            ip_out    <= {whi_reg, wlo_reg};
            sp_out    <= sp_reg - 16'd2;
            done      <= 1'b1;
            state_reg <= FIN;
          end
        end

        FIN: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          mem_req   <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_z80_call_cond_seq.sv
// Bench for z80_call_cond_seq: vector table plus bus/result scoreboards fed at
// stimulus time and drained by a negedge bus responder/monitor.
`timescale 1ns/1ps
module tb_z80_call_cond_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  opcode = 8'h00;
  logic [7:0]  reg_f = 8'h00;
  logic [15:0] ip_in = 16'h0000;
  logic [15:0] sp_in = 16'h0000;
  logic        mem_req, mem_wr;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [2:0]  mem_tcycles;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic        busy, done, taken, err;
  logic [15:0] ip_out, sp_out;

  z80_call_cond_seq dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .reg_f(reg_f),
    .ip_in(ip_in), .sp_in(sp_in), .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_tcycles(mem_tcycles),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .done(done),
    .taken(taken), .ip_out(ip_out), .sp_out(sp_out), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [2:0]  tcyc;
  } bus_t;

  typedef struct {
    logic        taken;
    logic [15:0] ip;
    logic [15:0] sp;
    int          lat;
  } res_t;

  typedef struct {
    logic [7:0]  opcode;
    logic [7:0]  f;
    logic [15:0] ip;
    logic [15:0] sp;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic        exp_taken;
    logic [15:0] exp_ip;
    logic [15:0] exp_sp;
  } vec_t;

  bus_t bus_q[$];
  res_t res_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   ack_delay = 0;
  bit   spurious = 1'b0;
  int   err_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Bus responder and scoreboard consumer; all sampling on the falling edge.
  initial begin : responder
    bus_t cur;
    res_t r;
    bit   req_prev;
    bit   ack_prev;
    int   waitc;
    req_prev = 1'b0;
    ack_prev = 1'b0;
    waitc = 0;
    cur = '{1'b0, 16'h0000, 8'h00, 3'd0};
    forever begin
      @(negedge clk);
      if (err) err_cnt++;
      if (ack_prev) check("req_drop_after_ack", 32'(mem_req), 32'd0);
      if (mem_req && !req_prev) begin
        waitc = 0;
        if (bus_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_bus: req wr=%0d addr=%0h with no transfer pending", mem_wr, mem_addr);
          cur = '{mem_wr, mem_addr, mem_wdata, mem_tcycles};
        end else begin
          cur = bus_q.pop_front();
          check("bus_wr", 32'(mem_wr), 32'(cur.wr));
          check("bus_addr", 32'(mem_addr), 32'(cur.addr));
          check("bus_tcycles", 32'(mem_tcycles), 32'(cur.tcyc));
          if (cur.wr) check("bus_wdata", 32'(mem_wdata), 32'(cur.data));
        end
      end else if (mem_req) begin
        check("stable_addr", 32'(mem_addr), 32'(cur.addr));
        check("stable_wr", 32'(mem_wr), 32'(cur.wr));
        check("stable_tcycles", 32'(mem_tcycles), 32'(cur.tcyc));
        if (cur.wr) check("stable_wdata", 32'(mem_wdata), 32'(cur.data));
      end
      if (mem_req) begin
        if (waitc >= ack_delay) begin
          mem_ack = 1'b1;
          if (!cur.wr) mem_rdata = cur.data;
          waitc = 0;
        end else begin
          mem_ack = 1'b0;
          waitc++;
        end
      end else begin
        mem_ack = spurious;
        mem_rdata = 8'hEE;
      end
      ack_prev = mem_req && mem_ack;
      req_prev = mem_req;

      if (done) begin
        if (res_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: taken=%0d ip_out=%0h with no instruction pending", taken, ip_out);
        end else begin
          r = res_q.pop_front();
          check("taken", 32'(taken), 32'(r.taken));
          check("ip_out", 32'(ip_out), 32'(r.ip));
          check("sp_out", 32'(sp_out), 32'(r.sp));
          check("busy_at_done", 32'(busy), 32'd1);
          if (r.lat != 0) check("latency", 32'(cyc - start_cyc), 32'(r.lat));
        end
      end
    end
  end

  task automatic issue(input vec_t v, input int lat);
    bus_t        b;
    res_t        r;
    logic [15:0] ret;
    ret = v.ip + 16'h0003;
    b = '{1'b0, v.ip + 16'h0001, v.lo, 3'd3};
    bus_q.push_back(b);
    b = '{1'b0, v.ip + 16'h0002, v.hi, v.exp_taken ? 3'd4 : 3'd3};
    bus_q.push_back(b);
    if (v.exp_taken) begin
      b = '{1'b1, v.sp - 16'h0001, ret[15:8], 3'd3};
      bus_q.push_back(b);
      b = '{1'b1, v.sp - 16'h0002, ret[7:0], 3'd3};
      bus_q.push_back(b);
    end
    r = '{v.exp_taken, v.exp_ip, v.exp_sp, lat};
    res_q.push_back(r);
    @(negedge clk);
    start = 1'b1;
    opcode = v.opcode;
    reg_f = v.f;
    ip_in = v.ip;
    sp_in = v.sp;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    reg_f = ~v.f;
    opcode = 8'h00;
    ip_in = 16'hDEAD;
    sp_in = 16'hBEEF;
  endtask

  task automatic wait_done(input vec_t v, input string name);
    int n;
    n = 0;
    while (res_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (res_q.size() == 0) passes++;
    else begin
      $display("FAIL %s_timeout: no done after %0d cycles, required within 300", name, n);
      res_q.delete();
    end
    check({name, "_bus_left"}, 32'(bus_q.size()), 32'd0);
    bus_q.delete();
    @(negedge clk);
    check({name, "_busy_after"}, 32'(busy), 32'd0);
    check({name, "_held_ip"}, 32'(ip_out), 32'(v.exp_ip));
    check({name, "_held_taken"}, 32'(taken), 32'(v.exp_taken));
    $display("txn %s: opcode=%0h f=%0h ip=%0h sp=%0h -> taken=%0d ip_out=%0h sp_out=%0h",
             name, v.opcode, v.f, v.ip, v.sp, taken, ip_out, sp_out);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t        vecs[19];
    logic [2:0]  c;
    logic [7:0]  f;
    logic [7:0]  opc;
    logic        t;
    logic [15:0] ip;
    int          e0;
    int          n;

    vecs[0] = '{8'hC4, 8'h00, 16'h1000, 16'h8000, 8'h34, 8'h12, 1'b1, 16'h1234, 16'h7FFE};
    vecs[1] = '{8'hCC, 8'h00, 16'h1000, 16'h8000, 8'h34, 8'h12, 1'b0, 16'h1003, 16'h8000};
    vecs[2] = '{8'hCD, 8'h00, 16'hFFFE, 16'h0000, 8'h78, 8'h56, 1'b1, 16'h5678, 16'hFFFE};
    // All four tested flags are equal in 0x00 and 0xC5, so taken depends only on cond[0].
    for (int i = 0; i < 16; i++) begin
      c = 3'(i >> 1);
      f = (i % 2 != 0) ? 8'hC5 : 8'h00;
      t = (f == 8'h00) ? ~c[0] : c[0];
      opc = 8'hC4 | {2'b00, c, 3'b000};
      ip = 16'h2000 + 16'(i * 16);
      vecs[3 + i] = '{opc, f, ip, 16'h9000, 8'(i), 8'hA0, t,
                      t ? {8'hA0, 8'(i)} : ip + 16'h0003,
                      t ? 16'h8FFE : 16'h9000};
    end

    repeat (3) @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_busy_done_err", 32'({busy, done, err, taken, mem_wr}), 32'd0);
    check("rst_ip_sp_out", 32'({ip_out, sp_out}), 32'd0);
    check("rst_bus_fields", 32'({mem_addr, mem_wdata, mem_tcycles}), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      issue(vecs[i], vecs[i].exp_taken ? 9 : 5);
      wait_done(vecs[i], $sformatf("vec%0d", i));
    end

    // Unsupported opcode
    @(negedge clk);
    start = 1'b1;
    opcode = 8'hC9;
    @(negedge clk);
    start = 1'b0;
    check("err_pulse", 32'(err), 32'd1);
    check("err_no_req", 32'(mem_req), 32'd0);
    check("err_not_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("err_one_cycle", 32'(err), 32'd0);
    check("err_no_req_later", 32'(mem_req), 32'd0);
    $display("txn err: opcode=c9 -> err pulse seen");

    // Stalled bus, stray acks, and start pulses while busy
    ack_delay = 3;
    spurious = 1'b1;
    e0 = err_cnt;
    issue(vecs[0], 0);
    repeat (5) @(negedge clk);
    start = 1'b1;
    opcode = 8'hC9;
    @(negedge clk);
    opcode = 8'hCC;
    reg_f = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    wait_done(vecs[0], "stall");
    check("stall_no_err", 32'(err_cnt - e0), 32'd0);
    ack_delay = 0;
    spurious = 1'b0;

    // Reset while the first push is outstanding
    ack_delay = 2;
    issue(vecs[0], 0);
    n = 0;
    while (!(mem_req && mem_wr) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rst_reached_wr_hi", 32'(mem_req && mem_wr), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_req", 32'(mem_req), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    bus_q.delete();
    res_q.delete();
    ack_delay = 0;
    repeat (12) @(negedge clk);
    check("rst_idle_after", 32'({busy, mem_req}), 32'd0);
    $display("txn reset: aborted during WR_HI, sequencer idle");

    issue(vecs[1], 5);
    wait_done(vecs[1], "recover");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
